// File: rtl/period_meter_pkg.sv
// ============================================================================
// period_meter_pkg : shared state encoding and default sizing constants
// Revision: 1.0
// ============================================================================
`default_nettype none

package period_meter_pkg;

  typedef enum logic {
    S_ARM = 1'b0,
    S_RUN = 1'b1
  } meas_state_t;

  localparam int DEF_CNT_W      = 32;
  localparam int DEF_TIMEOUT    = 50_000_000;
  // The divider's max-count equals the default timeout window.
  localparam int DIV_MAX_COUNT  = DEF_TIMEOUT;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

`default_nettype wire

// File: rtl/period_meter_sync_edge_det.sv
// ============================================================================
// sync_edge_det : multi-flop synchroniser plus history flop; emits rise/fall
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic sig_in,
  output logic rise,
  output logic fall,
  output logic level
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

`default_nettype wire

// File: rtl/period_meter.sv
// ============================================================================
// period_meter : measures period and high time of a slow async square wave
//   and publishes results on a valid/ready port.
//   Optional: PERIOD_AVG_EN averages four measurements per published result.
// Revision: 1.0
// ============================================================================
`default_nettype none

module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             timeout,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             rise;
  logic             fall;
  logic             level_unused;

  meas_state_t      state;
  meas_state_t      state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;

  logic             cnt_start;
  logic             meas_done;
  logic             to_evt;
  logic             hcap;

  logic             pub;
  logic [CNT_W-1:0] pub_period;
  logic [CNT_W-1:0] pub_high;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_det (
    .clk_in (clk_in),
    .rst    (rst),
    .sig_in (sig_in),
    .rise   (rise),
    .fall   (fall),
    .level  (level_unused)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state <= S_ARM;
    end else begin
      state <= state_nx;
    end
  end

  // A rise in the same cycle as cnt reaching TIMEOUT still counts as a measurement.
  always_comb begin
    state_nx  = state;
    cnt_start = 1'b0;
    meas_done = 1'b0;
    to_evt    = 1'b0;
    hcap      = 1'b0;
    case (state)
      S_ARM: begin
        if (rise) begin
          cnt_start = 1'b1;
          state_nx  = S_RUN;
        end
      end
      S_RUN: begin
        if (rise) begin
          meas_done = 1'b1;
          cnt_start = 1'b1;
        end else if (cnt == TIMEOUT_CNT) begin
          to_evt   = 1'b1;
          state_nx = S_ARM;
        end
        if (fall) begin
          hcap = 1'b1;
        end
      end
      default: state_nx = S_ARM;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      hcnt <= '0;
    end else begin
      if (cnt_start) begin
        cnt <= CNT_ONE;
      end else if (to_evt) begin
        cnt <= '0;
      end else if (state == S_RUN) begin
        cnt <= cnt + CNT_ONE;
      end

      if (to_evt) begin
        hcnt <= '0;
      end else if (hcap) begin
        hcnt <= cnt;
      end
    end
  end

`ifdef PERIOD_AVG_EN
  logic [CNT_W+1:0] acc_p;
  logic [CNT_W+1:0] acc_h;
  logic [CNT_W+1:0] sum_p;
  logic [CNT_W+1:0] sum_h;
  logic [1:0]       nsamp;

  assign sum_p = acc_p + {2'b00, cnt};
  assign sum_h = acc_h + {2'b00, hcnt};

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      acc_p <= '0;
      acc_h <= '0;
      nsamp <= 2'd0;
    end else if (to_evt || (meas_done && nsamp == 2'd3)) begin
      acc_p <= '0;
      acc_h <= '0;
      nsamp <= 2'd0;
    end else if (meas_done) begin
      acc_p <= sum_p;
      acc_h <= sum_h;
      nsamp <= nsamp + 2'd1;
    end
  end

  assign pub        = meas_done && (nsamp == 2'd3);
  assign pub_period = CNT_W'(sum_p >> 2);
  assign pub_high   = CNT_W'(sum_h >> 2);
`else
  assign pub        = meas_done;
  assign pub_period = cnt;
  assign pub_high   = hcnt;
`endif

  // An unaccepted result is never overwritten; the newer one is dropped instead.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      period_out <= '0;
      high_out   <= '0;
      out_valid  <= 1'b0;
      timeout    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (pub) begin
        if (!out_valid || out_ready) begin
          period_out <= pub_period;
          high_out   <= pub_high;
          out_valid  <= 1'b1;
          timeout    <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (to_evt) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_period_meter.sv
// ============================================================================
// tb_period_meter : directed self-checking bench for period_meter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_period_meter;

  localparam int CNT_W = 16;

  logic             clk_in = 1'b0;
  logic             rst = 1'b1;
  logic             sig_in = 1'b0;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             out_valid;
  logic             timeout;
  logic             overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  period_meter #(
    .CNT_W       (CNT_W),
    .TIMEOUT     (100),
    .SYNC_STAGES (2)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .sig_in     (sig_in),
    .period_out (period_out),
    .high_out   (high_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .timeout    (timeout),
    .overrun    (overrun)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset;
    sig_in = 1'b0;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    n_cmp++; if ({out_valid, timeout, overrun} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got v/t/o=%b want 000", {out_valid, timeout, overrun}); end
    n_cmp++; if (period_out !== 16'd0) begin n_fail++; $display("FAIL reset_period: got %0d want 0", period_out); end
    n_cmp++; if (high_out !== 16'd0) begin n_fail++; $display("FAIL reset_high: got %0d want 0", high_out); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    do_reset;
    out_ready = 1'b1;
    sig_in = 1'b1; repeat (5) tick; sig_in = 1'b0; repeat (5) tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_rise: got valid=%b want 0", out_valid); end
    for (int p = 0; p < 3; p++) begin
      sig_in = 1'b1;
      tick; tick;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early[%0d]: got valid=%b want 0", p, out_valid); end
      tick;
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid[%0d]: got %b want 1", p, out_valid); end
      n_cmp++; if (period_out !== 16'd10) begin n_fail++; $display("FAIL basic_period[%0d]: got %0d want 10", p, period_out); end
      n_cmp++; if (high_out !== 16'd5) begin n_fail++; $display("FAIL basic_high[%0d]: got %0d want 5", p, high_out); end
      tick;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_accept[%0d]: got valid=%b want 0", p, out_valid); end
      tick;
      sig_in = 1'b0; repeat (5) tick;
    end
  endtask

  task automatic test_back_to_back;
    do_reset;
    out_ready = 1'b0;
    sig_in = 1'b1; repeat (5) tick; sig_in = 1'b0; repeat (5) tick;
    sig_in = 1'b1; repeat (3) tick;
    n_cmp++; if (period_out !== 16'd10 || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got v=%b p=%0d want v=1 p=10", out_valid, period_out); end
    repeat (2) tick; sig_in = 1'b0; repeat (10) tick;
    sig_in = 1'b1; tick; tick;
    out_ready = 1'b1;
    tick;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
    n_cmp++; if (period_out !== 16'd15) begin n_fail++; $display("FAIL b2b_period: got %0d want 15", period_out); end
    n_cmp++; if (high_out !== 16'd5) begin n_fail++; $display("FAIL b2b_high: got %0d want 5", high_out); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drop: got valid=%b want 0", out_valid); end
    repeat (3) tick; sig_in = 1'b0; tick;
  endtask

  task automatic test_overrun;
    do_reset;
    out_ready = 1'b0;
    sig_in = 1'b1; repeat (12) tick; sig_in = 1'b0; repeat (25) tick;
    sig_in = 1'b1; repeat (3) tick;
    n_cmp++; if (out_valid !== 1'b1 || period_out !== 16'd37) begin n_fail++; $display("FAIL ovr_first: got v=%b p=%0d want v=1 p=37", out_valid, period_out); end
    n_cmp++; if (high_out !== 16'd12) begin n_fail++; $display("FAIL ovr_first_high: got %0d want 12", high_out); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early: got overrun=%b want 0", overrun); end
    repeat (9) tick; sig_in = 1'b0; repeat (8) tick;
    sig_in = 1'b1; repeat (3) tick;
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    n_cmp++; if (out_valid !== 1'b1 || period_out !== 16'd37 || high_out !== 16'd12) begin n_fail++; $display("FAIL ovr_held: got v=%b p=%0d h=%0d want 1/37/12", out_valid, period_out, high_out); end
    repeat (9) tick; sig_in = 1'b0; repeat (5) tick;
    n_cmp++; if (period_out !== 16'd37) begin n_fail++; $display("FAIL ovr_stable: got %0d want 37", period_out); end
    out_ready = 1'b1;
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_accept: got valid=%b want 0", out_valid); end
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_timeout;
    do_reset;
    out_ready = 1'b1;
    sig_in = 1'b1;
    repeat (102) tick;
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b want 0", timeout); end
    tick;
    n_cmp++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL to_set: got %b want 1", timeout); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL to_valid: got %b want 0", out_valid); end
    sig_in = 1'b0; repeat (10) tick;
    sig_in = 1'b1; repeat (3) tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL to_rearm: got valid=%b want 0", out_valid); end
    repeat (7) tick; sig_in = 1'b0; repeat (10) tick;
    sig_in = 1'b1; tick; tick;
    n_cmp++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL to_hold: got %b want 1", timeout); end
    tick;
    n_cmp++; if (out_valid !== 1'b1 || period_out !== 16'd20) begin n_fail++; $display("FAIL to_restart: got v=%b p=%0d want 1/20", out_valid, period_out); end
    n_cmp++; if (high_out !== 16'd10) begin n_fail++; $display("FAIL to_restart_high: got %0d want 10", high_out); end
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b want 0", timeout); end
    repeat (7) tick; sig_in = 1'b0; tick;
  endtask

  task automatic test_reset_mid;
    do_reset;
    out_ready = 1'b0;
    sig_in = 1'b1; repeat (5) tick; sig_in = 1'b0; repeat (5) tick;
    sig_in = 1'b1; repeat (3) tick;
    n_cmp++; if (out_valid !== 1'b1 || period_out !== 16'd10) begin n_fail++; $display("FAIL rm_pre: got v=%b p=%0d want 1/10", out_valid, period_out); end
    repeat (2) tick; sig_in = 1'b0; repeat (45) tick;
    rst = 1'b1;
    #2;
    n_cmp++; if (out_valid !== 1'b0 || period_out !== 16'd0 || high_out !== 16'd0) begin n_fail++; $display("FAIL rm_async: got v=%b p=%0d h=%0d want 0/0/0", out_valid, period_out, high_out); end
    tick; tick; tick;
    rst = 1'b0;
    out_ready = 1'b1;
    tick;
    sig_in = 1'b1; repeat (3) tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_first_rise: got valid=%b want 0", out_valid); end
    repeat (2) tick; sig_in = 1'b0; repeat (5) tick;
    sig_in = 1'b1; repeat (3) tick;
    n_cmp++; if (out_valid !== 1'b1 || period_out !== 16'd10 || high_out !== 16'd5) begin n_fail++; $display("FAIL rm_result: got v=%b p=%0d h=%0d want 1/10/5", out_valid, period_out, high_out); end
    repeat (2) tick; sig_in = 1'b0; repeat (5) tick;
  endtask

  task automatic test_avg;
    int iv [4];
    iv = '{10, 12, 14, 16};
    do_reset;
    out_ready = 1'b1;
    sig_in = 1'b1; repeat (5) tick; sig_in = 1'b0; repeat (iv[0] - 5) tick;
    for (int i = 1; i < 4; i++) begin
      sig_in = 1'b1; repeat (3) tick;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL avg_nopub[%0d]: got valid=%b want 0", i, out_valid); end
      repeat (2) tick; sig_in = 1'b0; repeat (iv[i] - 5) tick;
    end
    sig_in = 1'b1; repeat (3) tick;
    n_cmp++; if (out_valid !== 1'b1 || period_out !== 16'd13 || high_out !== 16'd5) begin n_fail++; $display("FAIL avg_13: got v=%b p=%0d h=%0d want 1/13/5", out_valid, period_out, high_out); end
    repeat (2) tick; sig_in = 1'b0; repeat (12) tick;
    for (int j = 0; j < 4; j++) begin
      sig_in = 1'b1; repeat (3) tick;
      if (j < 3) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL avg17_nopub[%0d]: got valid=%b want 0", j, out_valid); end
      end else begin
        n_cmp++; if (out_valid !== 1'b1 || period_out !== 16'd17) begin n_fail++; $display("FAIL avg_17: got v=%b p=%0d want 1/17", out_valid, period_out); end
      end
      repeat (2) tick; sig_in = 1'b0; repeat (12) tick;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifdef PERIOD_AVG_EN
    test_avg();
`else
    test_basic();
    test_back_to_back();
    test_overrun();
    test_timeout();
    test_reset_mid();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
